mem_access_stage: RTL and testbench

- Pipeline MEM stage: takes the current ex_mem operation and performs loads/stores over the shared byte-wide memory bus.
- Produces the mem_wd / mem_wreg / mem_wdata triple that the mem_wb register captures.
- Holds the pipeline via stall_req while the multi-byte transfer is in flight.
- Non-memory operations pass through combinationally with zero added latency.

---
 rtl/mem_access_stage_pkg.sv | 66 ++++++
 rtl/mem_access_stage_load_extend.sv | 26 ++
 rtl/mem_access_stage.sv | 198 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg
// Shared definitions for the MEM pipeline stage:
//   - memop_t      : memory operation codes carried in ex_mem
//   - byte_count   : number of bus bytes moved by an operation
//   - last_index   : index of the final byte of an operation
//   - is_load / is_store / misaligned : operation classification helpers
//   - ST_*         : FSM state encoding of the stage controller
//   - REG_ADDR_W / REG_W / ZERO_WORD / NOP_REG_ADDR : register-file widths
package mem_access_stage_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_W      = 32;

    localparam logic [REG_W-1:0]      ZERO_WORD    = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LH   = 4'd2,
        OP_LW   = 4'd3,
        OP_LBU  = 4'd4,
        OP_LHU  = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } memop_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Codes 9-15 fall into the default branch and move no bytes.
    function automatic logic [2:0] byte_count(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            OP_LW, OP_SW:         return 3'd4;
            default:              return 3'd0;
        endcase
    endfunction

    function automatic logic [1:0] last_index(input logic [3:0] op);
        logic [2:0] n;
        n = byte_count(op) - 3'd1;
        return n[1:0];
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return addr_lo[0];
            OP_LW, OP_SW:         return addr_lo != 2'd0;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// load_extend
// Combinational load-result formatter: takes the little-endian assembled
// word and the memory op, returns the sign- or zero-extended register value.
// Ports:
//   raw   in  32  assembled bytes, byte 0 in bits [7:0]
//   memop in  4   memory op code
//   value out 32  extended load value (raw word for LW / non-loads)
module load_extend
    import mem_access_stage_pkg::*;
(
    input  logic [REG_W-1:0] raw,
    input  logic [3:0]       memop,
    output logic [REG_W-1:0] value
);

    always_comb begin
        case (memop)
            OP_LB:   value = {{24{raw[7]}}, raw[7:0]};
            OP_LBU:  value = {24'h0, raw[7:0]};
            OP_LH:   value = {{16{raw[15]}}, raw[15:0]};
            OP_LHU:  value = {16'h0, raw[15:0]};
            default: value = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
// Pipeline MEM stage. Memory ops are carried out one byte per granted bus
// cycle over a shared byte-wide bus while stall_req holds the upstream
// pipeline; non-memory ops pass straight through to mem_wb.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ex_wd/ex_wreg/ex_wdata        destination, write enable, ALU value
//   ex_memop/ex_addr/ex_sdata     memory op, byte address, store data
//   mem_wd/mem_wreg/mem_wdata     result triple to mem_wb
//   stall_req                     hold ex_mem and earlier stages
//   mem_hold                      mem_wb stalled this cycle (keeps DONE)
//   bus_req/bus_we/bus_addr/bus_dout  byte request side of the bus
//   bus_din/bus_gnt               read byte (1 cycle after grant), grant
//   mem_misalign                  only when MEM_ALIGN_CHECK_EN is defined
// Build option: define MEM_ALIGN_CHECK_EN to reject misaligned halfword /
// word accesses without touching the bus.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [3:0]            ex_memop,
    input  logic [ADDR_W-1:0]     ex_addr,
    input  logic [DATA_W-1:0]     ex_sdata,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  stall_req,
    input  logic                  mem_hold,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [7:0]            bus_dout,
    input  logic [7:0]            bus_din,
    input  logic                  bus_gnt
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                  mem_misalign
`endif
);

    logic [1:0]        state_reg, state_next;
    logic [1:0]        issue_cnt_reg, issue_cnt_next;
    logic [1:0]        rcv_cnt_reg;
    logic              rd_pending_reg;
    logic              xfer_req;
    logic              bad_align;
    logic              done_misalign;
    logic [DATA_W-1:0] asm_word;
    logic [DATA_W-1:0] load_value;

    logic       op_load, op_store, op_mem;
    logic [1:0] last_idx;

    assign op_load  = is_load(ex_memop);
    assign op_store = is_store(ex_memop);
    assign op_mem   = op_load | op_store;
    assign last_idx = last_index(ex_memop);

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_reg;

    // Latched on the IDLE->DONE rejection and kept for as long as DONE is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_reg <= 1'b0;
        end else if (state_reg == ST_IDLE) begin
            misalign_reg <= op_mem & bad_align;
        end else if (state_reg != ST_DONE) begin
            misalign_reg <= 1'b0;
        end
    end

    assign bad_align     = misaligned(ex_memop, ex_addr[1:0]);
    assign done_misalign = misalign_reg;
    assign mem_misalign  = !rst && (state_reg == ST_DONE) && misalign_reg;
`else
    assign bad_align     = 1'b0;
    assign done_misalign = 1'b0;
`endif

    // Next-state logic. A request is made for byte 0 already in IDLE, so the
    // IDLE and XFER grant handling is shared below.
    always_comb begin
        state_next     = state_reg;
        issue_cnt_next = issue_cnt_reg;
        xfer_req       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (op_mem && bad_align) begin
                    state_next = ST_DONE;
                end else if (op_mem) begin
                    xfer_req = 1'b1;
                end
            end
            ST_XFER:  xfer_req = 1'b1;
            ST_DRAIN: state_next = ST_DONE;
            ST_DONE:  if (!mem_hold) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (xfer_req) begin
            state_next = ST_XFER;
            if (bus_gnt) begin
                if (issue_cnt_reg == last_idx) begin
                    issue_cnt_next = 2'd0;
                    state_next     = op_load ? ST_DRAIN : ST_DONE;
                end else begin
                    issue_cnt_next = issue_cnt_reg + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            issue_cnt_reg  <= 2'd0;
            rcv_cnt_reg    <= 2'd0;
            rd_pending_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            issue_cnt_reg  <= issue_cnt_next;
            // A granted read returns its byte on bus_din in the next cycle.
            rd_pending_reg <= xfer_req && bus_gnt && op_load;
            if (state_reg == ST_IDLE) begin
                rcv_cnt_reg <= 2'd0;
            end else if (rd_pending_reg) begin
                rcv_cnt_reg <= rcv_cnt_reg + 2'd1;
            end
        end
    end

    // Assembly register: one byte lane per returned byte, filled in arrival
    // order regardless of the FSM state it arrives in.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_reg;

        always_ff @(posedge clk) begin
            if (rst || state_reg == ST_IDLE) begin
                lane_reg <= 8'h00;
            end else if (rd_pending_reg && rcv_cnt_reg == 2'(gi)) begin
                lane_reg <= bus_din;
            end
        end

        assign asm_word[8*gi +: 8] = lane_reg;
    end

    load_extend u_load_extend (
        .raw   (asm_word),
        .memop (ex_memop),
        .value (load_value)
    );

    // Bus side; everything is forced low during reset.
    assign bus_req  = !rst && xfer_req;
    assign bus_we   = !rst && xfer_req && op_store;
    assign bus_addr = bus_req ? ex_addr + ADDR_W'(issue_cnt_reg) : '0;
    assign bus_dout = bus_req ? ex_sdata[{issue_cnt_reg, 3'b000} +: 8] : 8'h00;

    // Result side: zero while a transfer is in flight so nothing partial is
    // forwarded; pass-through for non-memory ops in IDLE.
    always_comb begin
        mem_wd    = NOP_REG_ADDR;
        mem_wreg  = 1'b0;
        mem_wdata = ZERO_WORD;
        stall_req = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_IDLE: begin
                    if (op_mem) begin
                        stall_req = 1'b1;
                    end else begin
                        mem_wd    = ex_wd;
                        mem_wreg  = ex_wreg;
                        mem_wdata = ex_wdata;
                    end
                end
                ST_XFER, ST_DRAIN: stall_req = 1'b1;
                default: begin
                    mem_wd = ex_wd;
                    if (!done_misalign) begin
                        mem_wreg  = ex_wreg;
                        mem_wdata = op_load ? load_value : ex_wdata;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_memop;
    logic [31:0] ex_addr;
    logic [31:0] ex_sdata;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        stall_req;
    logic        mem_hold;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din;
    logic        bus_gnt;
`ifdef MEM_ALIGN_CHECK_EN
    logic        mem_misalign;
`endif

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_wd     (ex_wd),
        .ex_wreg   (ex_wreg),
        .ex_wdata  (ex_wdata),
        .ex_memop  (ex_memop),
        .ex_addr   (ex_addr),
        .ex_sdata  (ex_sdata),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .stall_req (stall_req),
        .mem_hold  (mem_hold),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_dout  (bus_dout),
        .bus_din   (bus_din),
        .bus_gnt   (bus_gnt)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .mem_misalign (mem_misalign)
`endif
    );

    // Bus model: logs granted bytes mid-cycle, returns read data on bus_din
    // for exactly the cycle after the grant, junk otherwise.
    logic [7:0]  mem_img [logic [31:0]];
    int          gnt_count = 0;
    logic [31:0] log_addr [64];
    logic        log_we   [64];
    logic [7:0]  log_dout [64];
    logic        rd_due  = 1'b0;
    logic [31:0] rd_addr = 32'h0;

    always @(negedge clk) begin
        rd_due = 1'b0;
        if (!rst && bus_req && bus_gnt) begin
            log_addr[gnt_count % 64] = bus_addr;
            log_we[gnt_count % 64]   = bus_we;
            log_dout[gnt_count % 64] = bus_dout;
            gnt_count++;
            rd_due  = !bus_we;
            rd_addr = bus_addr;
        end
    end

    always @(posedge clk) begin
        if (rd_due) bus_din <= mem_img.exists(rd_addr) ? mem_img[rd_addr] : 8'h00;
        else        bus_din <= 8'hEE;
    end

    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    // Starts at the beginning of cycle 0 (inputs already driven) and returns
    // at mid-cycle of the first cycle with stall_req low.
    task automatic run_until_done(output int stall_cycles, output bit fwd_ok, output bit timed_out);
        stall_cycles = 0;
        fwd_ok       = 1'b1;
        timed_out    = 1'b0;
        look();
        while (stall_req === 1'b1) begin
            if (mem_wreg !== 1'b0 || mem_wdata !== 32'h0 || mem_wd !== 5'h0) fwd_ok = 1'b0;
            stall_cycles++;
            if (stall_cycles > 30) begin
                timed_out = 1'b1;
                break;
            end
            go();
            look();
        end
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] wdata;
        logic [4:0]  wd;
        logic        wreg;
        logic        misal;
        int          exp_stall;
        logic [31:0] exp_wdata;
        logic        exp_wreg;
        int          exp_gnts;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        int  sc;
        bit  fok;
        bit  tmo;
        int  base;
        int  total;

        vecs[0]  = '{"none",    OP_NONE, 32'h0,      32'h0,        32'h00001234, 5'd5, 1'b1, 1'b0, 0, 32'h00001234, 1'b1, 0};
        vecs[1]  = '{"lw",      OP_LW,   32'h100,    32'h0,        32'h0,        5'd7, 1'b1, 1'b0, 5, 32'h12345678, 1'b1, 4};
        vecs[2]  = '{"lb",      OP_LB,   32'h7,      32'h0,        32'h0,        5'd3, 1'b1, 1'b0, 2, 32'hFFFFFF80, 1'b1, 1};
        vecs[3]  = '{"lbu",     OP_LBU,  32'h7,      32'h0,        32'h0,        5'd3, 1'b1, 1'b0, 2, 32'h00000080, 1'b1, 1};
        vecs[4]  = '{"lh",      OP_LH,   32'h200,    32'h0,        32'h0,        5'd9, 1'b1, 1'b0, 3, 32'hFFFFF234, 1'b1, 2};
        vecs[5]  = '{"lhu",     OP_LHU,  32'h200,    32'h0,        32'h0,        5'd9, 1'b1, 1'b0, 3, 32'h0000F234, 1'b1, 2};
        vecs[6]  = '{"lw_mis",  OP_LW,   32'h2FF,    32'h0,        32'h0,        5'd2, 1'b1, 1'b1, 5, 32'h44332211, 1'b1, 4};
        vecs[7]  = '{"sw",      OP_SW,   32'h400,    32'hDEADBEEF, 32'h00000055, 5'd0, 1'b0, 1'b0, 4, 32'h00000055, 1'b0, 4};
        vecs[8]  = '{"sb",      OP_SB,   32'h500,    32'h000000A5, 32'h00000066, 5'd0, 1'b0, 1'b0, 1, 32'h00000066, 1'b0, 1};
        vecs[9]  = '{"op12",    4'd12,   32'h0,      32'h0,        32'hCAFEF00D, 5'd9, 1'b1, 1'b0, 0, 32'hCAFEF00D, 1'b1, 0};
        vecs[10] = '{"lb_pos",  OP_LB,   32'h101,    32'h0,        32'h0,        5'd4, 1'b1, 1'b0, 2, 32'h00000056, 1'b1, 1};

        mem_img[32'h100] = 8'h78; mem_img[32'h101] = 8'h56;
        mem_img[32'h102] = 8'h34; mem_img[32'h103] = 8'h12;
        mem_img[32'h7]   = 8'h80;
        mem_img[32'h200] = 8'h34; mem_img[32'h201] = 8'hF2;
        mem_img[32'h2FF] = 8'h11; mem_img[32'h300] = 8'h22;
        mem_img[32'h301] = 8'h33; mem_img[32'h302] = 8'h44;

        // Reset with a live memory op on the inputs: everything must read 0.
        rst = 1'b1; mem_hold = 1'b0; bus_gnt = 1'b1;
        ex_memop = OP_LW; ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234;
        ex_addr = 32'h100; ex_sdata = 32'h0;
        go(); go(); look();
        check32("rst_bus_req",   32'(bus_req),   32'h0);
        check32("rst_stall",     32'(stall_req), 32'h0);
        check32("rst_mem_wreg",  32'(mem_wreg),  32'h0);
        check32("rst_mem_wdata", mem_wdata,      32'h0);
        check32("rst_mem_wd",    32'(mem_wd),    32'h0);
        go();
        rst = 1'b0; ex_memop = OP_NONE;
        go();

        // Table-driven transactions, grant always asserted.
        for (int i = 0; i < NV; i++) begin
            int   exp_stall;
            int   exp_gnts;
            logic [31:0] exp_wdata;
            logic exp_wreg;
            exp_stall = vecs[i].exp_stall;
            exp_gnts  = vecs[i].exp_gnts;
            exp_wdata = vecs[i].exp_wdata;
            exp_wreg  = vecs[i].exp_wreg;
`ifdef MEM_ALIGN_CHECK_EN
            if (vecs[i].misal) begin
                exp_stall = 1; exp_gnts = 0; exp_wdata = 32'h0; exp_wreg = 1'b0;
            end
`endif
            base     = gnt_count;
            ex_memop = vecs[i].op;
            ex_addr  = vecs[i].addr;
            ex_sdata = vecs[i].sdata;
            ex_wdata = vecs[i].wdata;
            ex_wd    = vecs[i].wd;
            ex_wreg  = vecs[i].wreg;
            run_until_done(sc, fok, tmo);
            if (tmo) begin
                checks++; errors++;
                $display("FAIL %s_timeout: stall_req never dropped within 30 cycles", vecs[i].name);
            end
            $display("vec %0d %s: stall=%0d wdata=0x%08h wreg=%0d grants=%0d",
                     i, vecs[i].name, sc, mem_wdata, mem_wreg, gnt_count - base);
            check32({vecs[i].name, "_stall"}, 32'(sc), 32'(exp_stall));
            check32({vecs[i].name, "_wdata"}, mem_wdata, exp_wdata);
            check32({vecs[i].name, "_wreg"},  32'(mem_wreg), 32'(exp_wreg));
            check32({vecs[i].name, "_wd"},    32'(mem_wd), 32'(vecs[i].wd));
            check32({vecs[i].name, "_nofwd"}, 32'(fok), 32'h1);
            check32({vecs[i].name, "_busidle"}, 32'(bus_req), 32'h0);
            check32({vecs[i].name, "_grants"}, 32'(gnt_count - base), 32'(exp_gnts));
`ifdef MEM_ALIGN_CHECK_EN
            check32({vecs[i].name, "_misalign"}, 32'(mem_misalign), 32'(vecs[i].misal));
`endif
            for (int k = 0; k < exp_gnts && k < gnt_count - base; k++) begin
                logic [31:0] sd;
                sd = vecs[i].sdata;
                check32({vecs[i].name, "_addr"}, log_addr[(base + k) % 64], vecs[i].addr + 32'(k));
                check32({vecs[i].name, "_we"}, 32'(log_we[(base + k) % 64]), 32'(is_store(vecs[i].op)));
                if (is_store(vecs[i].op))
                    check32({vecs[i].name, "_dout"}, 32'(log_dout[(base + k) % 64]), 32'(sd[8*k +: 8]));
            end
            go();
            ex_memop = OP_NONE;
        end
        go();

`ifndef MEM_ALIGN_CHECK_EN
        // SH across the address wrap with grant pattern 1,0,1.
        ex_memop = OP_SH; ex_addr = 32'hFFFFFFFF; ex_sdata = 32'h0000ABCD;
        ex_wdata = 32'h77; ex_wd = 5'd0; ex_wreg = 1'b0; bus_gnt = 1'b1;
        look();
        $display("sh c0: req=%0d addr=0x%08h dout=0x%02h", bus_req, bus_addr, bus_dout);
        check32("sh_c0_addr",  bus_addr,        32'hFFFFFFFF);
        check32("sh_c0_dout",  32'(bus_dout),   32'hCD);
        check32("sh_c0_we",    32'(bus_we),     32'h1);
        go(); bus_gnt = 1'b0; look();
        $display("sh c1: req=%0d addr=0x%08h dout=0x%02h", bus_req, bus_addr, bus_dout);
        check32("sh_c1_req",   32'(bus_req),    32'h1);
        check32("sh_c1_addr",  bus_addr,        32'h00000000);
        check32("sh_c1_dout",  32'(bus_dout),   32'hAB);
        check32("sh_c1_stall", 32'(stall_req),  32'h1);
        go(); bus_gnt = 1'b1; look();
        $display("sh c2: req=%0d addr=0x%08h dout=0x%02h", bus_req, bus_addr, bus_dout);
        check32("sh_c2_addr",  bus_addr,        32'h00000000);
        check32("sh_c2_dout",  32'(bus_dout),   32'hAB);
        go(); look();
        $display("sh c3: stall=%0d wdata=0x%08h", stall_req, mem_wdata);
        check32("sh_c3_stall", 32'(stall_req),  32'h0);
        check32("sh_c3_wdata", mem_wdata,       32'h77);
        go();
        ex_memop = OP_NONE;
        go();
`endif

        // LW held in DONE by mem_hold for 3 cycles, then an identical LW.
        mem_hold = 1'b1;
        ex_memop = OP_LW; ex_addr = 32'h100; ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'h0;
        base = gnt_count;
        run_until_done(sc, fok, tmo);
        check32("hold_stall", 32'(sc), 32'd5);
        for (int i = 0; i < 4; i++) begin
            $display("hold cycle %0d: stall=%0d wdata=0x%08h req=%0d", i, stall_req, mem_wdata, bus_req);
            check32("hold_wdata", mem_wdata,        32'h12345678);
            check32("hold_wreg",  32'(mem_wreg),    32'h1);
            check32("hold_stall0", 32'(stall_req), 32'h0);
            check32("hold_busreq", 32'(bus_req),    32'h0);
            if (i < 3) begin
                go();
                if (i == 2) mem_hold = 1'b0;
                look();
            end
        end
        check32("hold_grants", 32'(gnt_count - base), 32'd4);
        base = gnt_count;
        go();
        run_until_done(sc, fok, tmo);
        $display("repeat lw: stall=%0d wdata=0x%08h grants=%0d", sc, mem_wdata, gnt_count - base);
        check32("rep_stall",  32'(sc), 32'd5);
        check32("rep_grants", 32'(gnt_count - base), 32'd4);
        check32("rep_wdata",  mem_wdata, 32'h12345678);
        go();
        ex_memop = OP_NONE;
        go();

        // Reset after byte 1 of an SW, then the same SW restarts from byte 0.
        ex_memop = OP_SW; ex_addr = 32'h400; ex_sdata = 32'h11223344;
        ex_wdata = 32'h99; ex_wd = 5'd4; ex_wreg = 1'b1;
        go();
        go();
        rst = 1'b1;
        look();
        $display("sw rst: req=%0d stall=%0d wdata=0x%08h wreg=%0d", bus_req, stall_req, mem_wdata, mem_wreg);
        check32("swrst_req",   32'(bus_req),   32'h0);
        check32("swrst_stall", 32'(stall_req), 32'h0);
        check32("swrst_wdata", mem_wdata,      32'h0);
        check32("swrst_wreg",  32'(mem_wreg),  32'h0);
        go();
        rst = 1'b0;
        base = gnt_count;
        look();
        $display("sw restart: req=%0d addr=0x%08h dout=0x%02h", bus_req, bus_addr, bus_dout);
        check32("swre_req",  32'(bus_req),  32'h1);
        check32("swre_addr", bus_addr,      32'h400);
        check32("swre_dout", 32'(bus_dout), 32'h44);
        go();
        run_until_done(sc, fok, tmo);
        total = sc + 1;
        $display("sw restart done: stall=%0d grants=%0d", total, gnt_count - base);
        check32("swre_stall",  32'(total), 32'd4);
        check32("swre_grants", 32'(gnt_count - base), 32'd4);
        check32("swre_last_addr", log_addr[(base + 3) % 64], 32'h403);
        check32("swre_last_dout", 32'(log_dout[(base + 3) % 64]), 32'h11);
        check32("swre_wdata", mem_wdata, 32'h99);
        go();
        ex_memop = OP_NONE;
        go();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
